// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB bus defines plus types and helpers for the AHB SRAM slave.
// The defines below are the common bus widths and the HTRANS/HSIZE/HRESP codes.
`ifndef AHB_SRAM_SLAVE_DEFINES
`define AHB_SRAM_SLAVE_DEFINES
`define HADDR_BUS     32
`define HDATA_BUS     32
`define HTRANS_IDLE   2'b00
`define HTRANS_BUSY   2'b01
`define HTRANS_NONSEQ 2'b10
`define HTRANS_SEQ    2'b11
`define HSIZE_BYTE    3'b000
`define HSIZE_HALF    3'b001
`define HSIZE_WORD    3'b010
`define HRESP_OKAY    1'b0
`define HRESP_ERROR   1'b1
`endif

package ahb_sram_slave_pkg;

  // Slave FSM states. ERR1/ERR2 are only reachable when error checking is built in.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // Byte lanes touched by a transfer. Sizes above word behave as word and
  // misaligned low address bits are simply aligned down.
  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      `HSIZE_BYTE: byte_lanes = 4'b0001 << lane;
      `HSIZE_HALF: byte_lanes = lane[1] ? 4'b1100 : 4'b0011;
      default:     byte_lanes = 4'b1111;
    endcase
  endfunction

  // True for a transfer that must be answered with an ERROR response.
  function automatic logic transfer_illegal(input logic [2:0] size, input logic [1:0] lane,
                                            input logic beyond_array);
    transfer_illegal = beyond_array
                    || (size > `HSIZE_WORD)
                    || ((size == `HSIZE_HALF) && lane[0])
                    || ((size == `HSIZE_WORD) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/ahb_sram_slave_array.sv
// Word-organised storage with four byte write enables and a registered read port.
// Contents are never reset.
module sram_byte_array #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data
);

  logic [3:0][7:0] mem [DEPTH_WORDS];

  // Byte-masked write; read register only updates when a read is issued so
  // the data stays put through any wait states.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) mem[wr_addr][b] <= wr_data[8*b +: 8];
    end
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: single-cycle or wait-stated reads/writes into a
// byte-writable array, with write-to-read forwarding for back-to-back access.
// Optional macro AHB_SLV_ERR_EN enables the two-cycle ERROR response for
// misaligned, oversized or out-of-range transfers.
//
// Handshake: a transfer is taken when hsel_i & hready_i & htrans_i in
// {NONSEQ,SEQ}; its data phase ends on the first edge where hreadyout_o=1.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hsel_i,
  input  logic [1:0]            htrans_i,
  input  logic [`HADDR_BUS-1:0] haddr_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [2:0]            hburst_i,
  input  logic [3:0]            hprot_i,
  input  logic [`HDATA_BUS-1:0] hwdata_i,
  input  logic                  hready_i,
  output logic [`HDATA_BUS-1:0] hrdata_o,
  output logic                  hreadyout_o,
  output logic                  hresp_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  state_t state;
  state_t next_state;
  state_t accept_next;

  logic [1:0]            wait_cnt;
  logic                  pend_valid;
  logic                  pend_write;
  logic [AW-1:0]         pend_idx;
  logic [3:0]            pend_be;
  logic [3:0]            fwd_be;
  logic [`HDATA_BUS-1:0] fwd_data;
  logic [31:0]           sram_q;
  logic [`HDATA_BUS-1:0] read_word;

  logic          slot_open;
  logic          acc;
  logic          acc_err;
  logic          acc_ok;
  logic [AW-1:0] addr_idx;
  logic [3:0]    addr_be;
  logic          wr_commit;
  logic [3:0]    wr_be;
  logic          rd_issue;
  logic          rd_phase;
  logic          unused_inputs;

  // A new address phase can only be taken while the previous data phase is completing.
  assign slot_open = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign acc       = slot_open && hsel_i && hready_i
                  && ((htrans_i == `HTRANS_NONSEQ) || (htrans_i == `HTRANS_SEQ));
  assign addr_idx  = haddr_i[AW+1:2];
  assign addr_be   = byte_lanes(hsize_i, haddr_i[1:0]);

`ifdef AHB_SLV_ERR_EN
  assign acc_err = acc && transfer_illegal(hsize_i, haddr_i[1:0], |haddr_i[`HADDR_BUS-1:AW+2]);
  assign hresp_o = ((state == ST_ERR1) || (state == ST_ERR2)) ? `HRESP_ERROR : `HRESP_OKAY;
`else
  assign acc_err = 1'b0;
  assign hresp_o = `HRESP_OKAY;
`endif

  assign acc_ok    = acc && !acc_err;
  assign wr_commit = (state == ST_DATA) && pend_valid && pend_write;
  assign wr_be     = wr_commit ? pend_be : 4'b0000;
  assign rd_issue  = acc_ok && !hwrite_i;
  assign unused_inputs = ^{hburst_i, hprot_i, haddr_i};

  // Destination state for whatever the address phase presents this cycle.
  always_comb begin
    accept_next = ST_IDLE;
    if (acc_err)     accept_next = ST_ERR1;
    else if (acc_ok) accept_next = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
  end

  // Next-state and ready decode.
  always_comb begin
    next_state  = state;
    hreadyout_o = 1'b1;
    case (state)
      ST_IDLE: next_state = accept_next;
      ST_DATA: next_state = accept_next;
      ST_WAIT: begin
        hreadyout_o = 1'b0;
        next_state  = (wait_cnt == 2'd0) ? ST_DATA : ST_WAIT;
      end
`ifdef AHB_SLV_ERR_EN
      ST_ERR1: begin
        hreadyout_o = 1'b0;
        next_state  = ST_ERR2;
      end
      ST_ERR2: next_state = accept_next;
`endif
      default: next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Wait-state counter, loaded on entry to WAIT and counted down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 2'd0;
    end else if ((next_state == ST_WAIT) && (state != ST_WAIT)) begin
      wait_cnt <= WAIT_LOAD;
    end else if ((state == ST_WAIT) && (wait_cnt != 2'd0)) begin
      wait_cnt <= wait_cnt - 2'd1;
    end
  end

  // Address-phase capture for the data phase that follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_write <= 1'b0;
      pend_idx   <= '0;
      pend_be    <= 4'b0000;
    end else if (slot_open) begin
      pend_valid <= acc_ok;
      if (acc_ok) begin
        pend_write <= hwrite_i;
        pend_idx   <= addr_idx;
        pend_be    <= addr_be;
      end
    end
  end

  // A read issued on the same edge a write commits to the same word sees the
  // old array value; remember the written lanes so the read returns merged data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_be   <= 4'b0000;
      fwd_data <= '0;
    end else if (rd_issue) begin
      fwd_be   <= (wr_commit && (pend_idx == addr_idx)) ? pend_be : 4'b0000;
      fwd_data <= hwdata_i;
    end
  end

  // Merge forwarded lanes over the array output.
  always_comb begin
    read_word = '0;
    for (int b = 0; b < 4; b++) begin
      read_word[8*b +: 8] = fwd_be[b] ? fwd_data[8*b +: 8] : sram_q[8*b +: 8];
    end
  end

  assign rd_phase = pend_valid && !pend_write && ((state == ST_WAIT) || (state == ST_DATA));
  assign hrdata_o = rd_phase ? read_word : '0;

  sram_byte_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .rd_en   (rd_issue),
    .rd_addr (addr_idx),
    .rd_data (sram_q),
    .wr_be   (wr_be),
    .wr_addr (pend_idx),
    .wr_data (hwdata_i)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed plus light random test of ahb_sram_slave with zero and two wait states.
module tb_ahb_sram_slave;

  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hsel0, hsel2, hready0, hready2;
  logic [31:0] hrdata0, hrdata2;
  logic        hreadyout0, hreadyout2, hresp0, hresp2;

  // clock / reset block
  always #5 clk = ~clk;

  ahb_sram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .hsel_i(hsel0), .htrans_i(htrans), .haddr_i(haddr),
    .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst), .hprot_i(hprot),
    .hwdata_i(hwdata), .hready_i(hready0), .hrdata_o(hrdata0),
    .hreadyout_o(hreadyout0), .hresp_o(hresp0)
  );

  ahb_sram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .hsel_i(hsel2), .htrans_i(htrans), .haddr_i(haddr),
    .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst), .hprot_i(hprot),
    .hwdata_i(hwdata), .hready_i(hready2), .hrdata_o(hrdata2),
    .hreadyout_o(hreadyout2), .hresp_o(hresp2)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] model [int];
  int n_asserts = 0;
  int n_fail = 0;

  bit          cur;       // 0 -> dut0, 1 -> dut2
  bit          dp_valid;
  bit          dp_read;
  logic [31:0] dp_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'b000:  lane_mask = 32'h0000_00FF << (8 * a);
      3'b001:  lane_mask = a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic cur_ready();
    return cur ? hreadyout2 : hreadyout0;
  endfunction
  function automatic logic cur_resp();
    return cur ? hresp2 : hresp0;
  endfunction
  function automatic logic [31:0] cur_rdata();
    return cur ? hrdata2 : hrdata0;
  endfunction

  task automatic set_hready(input logic v);
    if (cur) hready2 = v;
    else     hready0 = v;
  endtask

  // driver: present one address phase (plus the data phase of the previous
  // transfer) on the active slave, riding out any wait states; called at negedge
  task automatic bus_cycle(input bit sel, input logic [1:0] trans, input bit wr,
                           input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int waits;
    int key;
    logic [31:0] mask;
    hwdata = dp_wdata;
    htrans = trans;
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
    hburst = 3'($urandom_range(0, 7));
    hprot  = 4'($urandom_range(0, 15));
    hsel0  = sel && !cur;
    hsel2  = sel && cur;
    waits  = 0;
    while ((cur_ready() !== 1'b1) && (waits < 8)) begin
      set_hready(1'b0);
      if (dp_valid && dp_read) check("rdata_hold", cur_rdata(), exp_q[0]);
      else                     check("rdata_zero_wait", cur_rdata(), 32'h0);
      check("resp_wait", 32'(cur_resp()), 32'h0);
      waits++;
      @(negedge clk);
    end
    set_hready(1'b1);
    check("ready", 32'(cur_ready()), 32'h1);
    check("resp", 32'(cur_resp()), 32'h0);
    check("wait_cycles", 32'(waits), (dp_valid && cur) ? 32'd2 : 32'd0);
    if (dp_valid && dp_read) check("rdata", cur_rdata(), exp_q.pop_front());
    else                     check("rdata_zero", cur_rdata(), 32'h0);
    dp_valid = sel && trans[1];
    dp_read  = !wr;
    dp_wdata = 32'($urandom);
    if (dp_valid) begin
      key = int'(cur) * DEPTH + int'((addr >> 2) % DEPTH);
      if (wr) begin
        mask = lane_mask(size, addr[1:0]);
        model[key] = (model[key] & ~mask) | (wdata & mask);
        dp_wdata = wdata;
      end else begin
        exp_q.push_back(model[key]);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    bus_cycle(1'b0, `HTRANS_IDLE, 1'b0, `HSIZE_WORD, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [2:0]  rsz;
    rst_n = 1'b0;
    htrans = `HTRANS_IDLE; haddr = '0; hwrite = 1'b0; hsize = `HSIZE_WORD;
    hburst = '0; hprot = '0; hwdata = '0;
    hsel0 = 1'b0; hsel2 = 1'b0; hready0 = 1'b1; hready2 = 1'b1;
    cur = 1'b0; dp_valid = 1'b0; dp_read = 1'b0; dp_wdata = '0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_ready0", 32'(hreadyout0), 32'h1);
    check("rst_resp0", 32'(hresp0), 32'h0);
    check("rst_rdata0", hrdata0, 32'h0);
    check("rst_ready2", 32'(hreadyout2), 32'h1);
    check("rst_rdata2", hrdata2, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // zero wait states: forwarding, byte/half lanes
    bus_cycle(1, `HTRANS_NONSEQ, 1, `HSIZE_WORD, 32'h10, 32'hDEAD_BEEF);
    bus_cycle(1, `HTRANS_NONSEQ, 0, `HSIZE_WORD, 32'h10, 32'h0);
    bus_cycle(1, `HTRANS_NONSEQ, 1, `HSIZE_WORD, 32'h10, 32'h1122_3344);
    bus_cycle(1, `HTRANS_NONSEQ, 1, `HSIZE_BYTE, 32'h13, 32'hAA00_0000);
    bus_cycle(1, `HTRANS_SEQ,    0, `HSIZE_WORD, 32'h10, 32'h0);
    bus_cycle(1, `HTRANS_NONSEQ, 1, `HSIZE_WORD, 32'h14, 32'h0102_0304);
    bus_cycle(1, `HTRANS_NONSEQ, 1, `HSIZE_HALF, 32'h16, 32'hBEEF_0000);
    idle_cycle();
    bus_cycle(1, `HTRANS_NONSEQ, 0, `HSIZE_WORD, 32'h14, 32'h0);
    bus_cycle(1, `HTRANS_NONSEQ, 0, `HSIZE_WORD, 32'h10, 32'h0);
    bus_cycle(1, `HTRANS_NONSEQ, 1, `HSIZE_HALF, 32'h10, 32'h0000_5555);
    bus_cycle(1, `HTRANS_NONSEQ, 1, `HSIZE_BYTE, 32'h11, 32'h0000_7700);
    idle_cycle();
    bus_cycle(1, `HTRANS_NONSEQ, 0, `HSIZE_WORD, 32'h10, 32'h0);

    // BUSY and deselected transfers leave the array alone
    bus_cycle(1, `HTRANS_BUSY,   1, `HSIZE_WORD, 32'h10, 32'hFFFF_FFFF);
    bus_cycle(0, `HTRANS_NONSEQ, 1, `HSIZE_WORD, 32'h10, 32'h0BAD_0BAD);
    bus_cycle(1, `HTRANS_NONSEQ, 0, `HSIZE_WORD, 32'h10, 32'h0);

`ifndef AHB_SLV_ERR_EN
    // without error checking: misaligned aligns down, oversize is word, addresses wrap
    bus_cycle(1, `HTRANS_NONSEQ, 0, `HSIZE_WORD, 32'h12, 32'h0);
    bus_cycle(1, `HTRANS_NONSEQ, 1, 3'b011, 32'h4014, 32'h600D_F00D);
    idle_cycle();
    bus_cycle(1, `HTRANS_NONSEQ, 0, `HSIZE_WORD, 32'h14, 32'h0);
`endif
    idle_cycle();

    // random legal traffic in a small window
    for (int i = 0; i < 8; i++)
      bus_cycle(1, `HTRANS_NONSEQ, 1, `HSIZE_WORD, 32'h100 + 32'(4 * i), 32'($urandom));
    for (int i = 0; i < 24; i++) begin
      rsz = 3'($urandom_range(0, 2));
      ra  = 32'h100 + 32'(4 * $urandom_range(0, 7));
      if (rsz == 3'd0)      ra = ra + 32'($urandom_range(0, 3));
      else if (rsz == 3'd1) ra = ra + 32'(2 * $urandom_range(0, 1));
      bus_cycle(1, ($urandom_range(0, 1) != 0) ? `HTRANS_NONSEQ : `HTRANS_SEQ,
                ($urandom_range(0, 1) != 0), rsz, ra, 32'($urandom));
    end
    idle_cycle();

    // two wait states
    cur = 1'b1;
    bus_cycle(1, `HTRANS_NONSEQ, 1, `HSIZE_WORD, 32'h20, 32'h5A5A_0001);
    idle_cycle();
    bus_cycle(1, `HTRANS_NONSEQ, 0, `HSIZE_WORD, 32'h20, 32'h0);
    bus_cycle(1, `HTRANS_NONSEQ, 1, `HSIZE_BYTE, 32'h21, 32'h0000_C300);
    bus_cycle(1, `HTRANS_NONSEQ, 0, `HSIZE_WORD, 32'h20, 32'h0);
    bus_cycle(1, `HTRANS_NONSEQ, 1, `HSIZE_WORD, 32'h40, 32'hCAFE_F00D);
    idle_cycle();
    idle_cycle();

    // reset during the WAIT of a write to 0x40
    hsel2 = 1'b1; htrans = `HTRANS_NONSEQ; haddr = 32'h40; hwrite = 1'b1; hsize = `HSIZE_WORD;
    @(negedge clk);
    check("pre_reset_wait", 32'(hreadyout2), 32'h0);
    hsel2 = 1'b0; htrans = `HTRANS_IDLE; hwdata = 32'h1234_5678; hready2 = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ready", 32'(hreadyout2), 32'h1);
    check("async_rst_resp", 32'(hresp2), 32'h0);
    check("async_rst_rdata", hrdata2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; hready2 = 1'b1; dp_valid = 1'b0;
    @(negedge clk);
    bus_cycle(1, `HTRANS_NONSEQ, 0, `HSIZE_WORD, 32'h40, 32'h0);
    idle_cycle();
    cur = 1'b0;

`ifdef AHB_SLV_ERR_EN
    // misaligned word read: two-cycle ERROR, then OKAY
    hsel0 = 1'b1; htrans = `HTRANS_NONSEQ; haddr = 32'h02; hwrite = 1'b0; hsize = `HSIZE_WORD;
    @(negedge clk);
    hsel0 = 1'b0; htrans = `HTRANS_IDLE;
    check("err1_ready", 32'(hreadyout0), 32'h0);
    check("err1_resp", 32'(hresp0), 32'h1);
    check("err1_rdata", hrdata0, 32'h0);
    hready0 = 1'b0;
    @(negedge clk);
    check("err2_ready", 32'(hreadyout0), 32'h1);
    check("err2_resp", 32'(hresp0), 32'h1);
    hready0 = 1'b1;
    @(negedge clk);
    check("post_err_resp", 32'(hresp0), 32'h0);
    check("post_err_ready", 32'(hreadyout0), 32'h1);
    // out-of-range write must not land anywhere
    hsel0 = 1'b1; htrans = `HTRANS_NONSEQ; haddr = 32'h4010; hwrite = 1'b1; hsize = `HSIZE_WORD;
    @(negedge clk);
    hsel0 = 1'b0; htrans = `HTRANS_IDLE; hwdata = 32'hFFFF_FFFF;
    check("oor_err1_resp", 32'(hresp0), 32'h1);
    hready0 = 1'b0;
    @(negedge clk);
    hready0 = 1'b1;
    @(negedge clk);
    bus_cycle(1, `HTRANS_NONSEQ, 0, `HSIZE_WORD, 32'h10, 32'h0);
    idle_cycle();
`endif

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  // bound on total run time
  initial begin
    #200000;
    $display("FAIL timeout: observed no end of test, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
